sd_init_ctrl: RTL and testbench

- SPI-mode SD card initialisation and single-block read sequencer. Sits directly upstream of the SD command engine and drives its command inputs and start strobe.
- Issues the power-up sequence CMD0, CMD8, CMD55/ACMD41 (repeated until ready), then CMD16.
- Once the card is ready, it turns host read requests into CMD17 transactions and returns the 32-bit data word.
- Checks every R1 response and latches an error code on any mismatch.

---
 rtl/sd_init_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_sd_init_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_init_ctrl.sv
// SPI-mode SD card bring-up sequencer (CMD0, CMD8, CMD55/ACMD41 loop, CMD16) and CMD17 single-word reader.
// Drives the SD command engine through a cmd_start/cmd_done level handshake and checks every R1 byte.
module sd_init_ctrl #(
    parameter int MAX_RETRY  = 1000,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_start,
    output logic        init_done,
    output logic        init_err,
    output logic [3:0]  err_code,
    output logic        busy,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [7:0]  cmd_number,
    output logic [31:0] cmd_args,
    output logic [7:0]  cmd_crc,
    output logic        cmd_start,
    input  logic        cmd_done,
    input  logic [7:0]  resp_flags,
    input  logic [31:0] resp_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_DONE, S_CHECK, S_GAP, S_READY, S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD16, STEP_CMD17
    } step_t;

    typedef struct packed {
        logic [7:0]  number;
        logic [31:0] args;
        logic [7:0]  crc;
    } cmd_t;

    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
    localparam logic [16:0] RETRY_LIMIT = 17'(MAX_RETRY);

    function automatic cmd_t cmd_lookup(input step_t s, input logic [31:0] addr);
        case (s)
            STEP_CMD0:   return '{8'h40, 32'h0000_0000, 8'h95};
            STEP_CMD8:   return '{8'h48, 32'h0000_01AA, 8'h87};
            STEP_CMD55:  return '{8'h77, 32'h0000_0000, 8'h01};
            STEP_ACMD41: return '{8'h69, 32'h4000_0000, 8'h01};
            STEP_CMD16:  return '{8'h50, 32'h0000_0200, 8'h01};
            default:     return '{8'h51, addr,          8'h01};
        endcase
    endfunction

    state_t      state, state_nxt;
    step_t       step, chk_step;
    logic [15:0] retry, retry_inc, gap_cnt;
    logic        seq_done, init_q, init_rise, restart, gap_over;
    logic [31:0] rd_addr_q, resp_data_q;
    logic [7:0]  resp_flags_q;
    logic        chk_ok, chk_last, chk_bump;
    logic [3:0]  chk_err;
    cmd_t        cmd_sel;

    // Edges arriving while a sequence is in flight are deliberately dropped.
    assign init_rise = init_start & ~init_q;
    assign restart   = init_rise && (state == S_IDLE || state == S_READY || state == S_ERROR);
    assign retry_inc = (retry == 16'hFFFF) ? retry : retry + 16'd1;
    assign gap_over  = (gap_cnt == GAP_LAST) && !cmd_done;
    assign cmd_sel   = cmd_lookup(step, rd_addr_q);

    // NOTE: every always_comb output gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        chk_ok   = 1'b0;
        chk_last = 1'b0;
        chk_bump = 1'b0;
        chk_err  = 4'd0;
        chk_step = step;
        case (step)
            STEP_CMD0:
                if (resp_flags_q == 8'h01) begin chk_ok = 1'b1; chk_step = STEP_CMD8; end
                else chk_err = 4'd1;
            STEP_CMD8:
                if (resp_flags_q == 8'h01) begin chk_ok = 1'b1; chk_step = STEP_CMD55; end
                else chk_err = 4'd2;
            STEP_CMD55:
                if (resp_flags_q <= 8'h01) begin chk_ok = 1'b1; chk_step = STEP_ACMD41; end
                else chk_err = 4'd3;
            STEP_ACMD41:
                if (resp_flags_q == 8'h00) begin
                    chk_ok   = 1'b1;
                    chk_step = STEP_CMD16;
                end else if (resp_flags_q == 8'h01) begin
                    chk_bump = 1'b1;
                    if ({1'b0, retry_inc} == RETRY_LIMIT) chk_err = 4'd5;
                    else begin chk_ok = 1'b1; chk_step = STEP_CMD55; end
                end else chk_err = 4'd4;
            STEP_CMD16:
                if (resp_flags_q == 8'h00) begin chk_ok = 1'b1; chk_last = 1'b1; end
                else chk_err = 4'd6;
            default:
                if (resp_flags_q == 8'h00) begin chk_ok = 1'b1; chk_last = 1'b1; end
                else chk_err = 4'd7;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (restart) state_nxt = S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (cmd_done) state_nxt = S_CHECK;
            S_CHECK:     state_nxt = chk_ok ? S_GAP : S_ERROR;
            S_GAP:       if (gap_over) state_nxt = seq_done ? S_READY : S_ISSUE;
            S_READY:     if (restart || rd_req) state_nxt = S_ISSUE;
            S_ERROR:     if (restart) state_nxt = S_ISSUE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_q       <= 1'b0;
            init_done    <= 1'b0;
            init_err     <= 1'b0;
            err_code     <= 4'd0;
            busy         <= 1'b0;
            rd_ready     <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= 32'd0;
            cmd_number   <= 8'd0;
            cmd_args     <= 32'd0;
            cmd_crc      <= 8'd0;
            cmd_start    <= 1'b0;
            step         <= STEP_CMD0;
            retry        <= 16'd0;
            gap_cnt      <= 16'd0;
            seq_done     <= 1'b0;
            rd_addr_q    <= 32'd0;
            resp_flags_q <= 8'd0;
            resp_data_q  <= 32'd0;
        end else begin
            init_q   <= init_start;
            rd_valid <= 1'b0;
            busy     <= !(state_nxt inside {S_IDLE, S_READY, S_ERROR});
            rd_ready <= (state_nxt == S_READY);
            init_err <= (state_nxt == S_ERROR);
            if (state_nxt == S_READY)                    init_done <= 1'b1;
            else if (restart || state_nxt == S_ERROR)    init_done <= 1'b0;

            if (restart) begin
                step     <= STEP_CMD0;
                retry    <= 16'd0;
                err_code <= 4'd0;
                seq_done <= 1'b0;
            end else if (state == S_READY && rd_req) begin
                step      <= STEP_CMD17;
                rd_addr_q <= rd_addr;
                seq_done  <= 1'b0;
            end

            case (state)
                S_ISSUE: begin
                    cmd_number <= cmd_sel.number;
                    cmd_args   <= cmd_sel.args;
                    cmd_crc    <= cmd_sel.crc;
                    cmd_start  <= 1'b1;
                end
                S_WAIT_DONE:
                    if (cmd_done) begin
                        cmd_start    <= 1'b0;
                        resp_flags_q <= resp_flags;
                        resp_data_q  <= resp_data;
                    end
                S_CHECK: begin
                    gap_cnt <= 16'd0;
                    if (chk_bump) retry <= retry_inc;
                    if (chk_ok) begin
                        step     <= chk_step;
                        seq_done <= chk_last;
                        if (step == STEP_CMD17) begin
                            rd_data  <= resp_data_q;
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        err_code <= chk_err;
                    end
                end
                S_GAP:
                    if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Randomised bench for sd_init_ctrl: an engine model answers commands from a scenario script and
// a list-based reference model predicts the command stream, error code and read results.
module tb_sd_init_ctrl;

    localparam int MAX_RETRY  = 4;
    localparam int GAP_CYCLES = 8;

    logic        clk = 1'b0, reset = 1'b0, init_start = 1'b0, rd_req = 1'b0;
    logic [31:0] rd_addr = 32'd0;
    logic        cmd_done = 1'b0;
    logic [7:0]  resp_flags = 8'd0;
    logic [31:0] resp_data = 32'd0;
    logic        init_done, init_err, busy, rd_ready, rd_valid, cmd_start;
    logic [3:0]  err_code;
    logic [31:0] rd_data, cmd_args;
    logic [7:0]  cmd_number, cmd_crc;

    sd_init_ctrl #(.MAX_RETRY(MAX_RETRY), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .reset(reset), .init_start(init_start), .init_done(init_done),
        .init_err(init_err), .err_code(err_code), .busy(busy), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .cmd_number(cmd_number), .cmd_args(cmd_args), .cmd_crc(cmd_crc),
        .cmd_start(cmd_start), .cmd_done(cmd_done), .resp_flags(resp_flags),
        .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  num;
        logic [31:0] args;
        logic [7:0]  crc;
    } cmd_rec_t;

    cmd_rec_t issued[$];
    cmd_rec_t expected[$];

    int checks = 0, errors = 0;
    int cyc = 0, valid_cnt = 0;
    logic [31:0] valid_data = 32'd0;

    // Scenario knobs read by the engine model.
    int          bad_step = -1, busy_n = 0, acmd_seen = 0, cmd55_seen = 0;
    logic [7:0]  bad_val = 8'd0;
    logic [31:0] rd_word = 32'd0;
    bit          stall_cmd8 = 1'b0, hold_rd = 1'b0, done_viol = 1'b0;
    int          fall_cyc = -1;
    int          eng_phase = 0, eng_delay = 0, eng_hold = 0;
    logic [7:0]  cur_num = 8'd0;
    logic [31:0] model_data = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_rec_t spec_cmd(input logic [7:0] num, input logic [31:0] addr);
        cmd_rec_t r;
        r.num  = num;
        r.args = 32'h0;
        r.crc  = 8'h01;
        case (num)
            8'h40: r.crc = 8'h95;
            8'h48: begin r.args = 32'h0000_01AA; r.crc = 8'h87; end
            8'h69: r.args = 32'h4000_0000;
            8'h50: r.args = 32'h0000_0200;
            8'h51: r.args = addr;
            default: ;
        endcase
        return r;
    endfunction

    function automatic bit allowed(input int s, input logic [7:0] v);
        case (s)
            0, 1:    return v == 8'h01;
            2, 3:    return v <= 8'h01;
            4, 5:    return v == 8'h00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] pick_bad(input int s);
        logic [7:0] v;
        do v = 8'($urandom_range(0, 127)); while (allowed(s, v));
        return v;
    endfunction

    // Walks the power-up rules: which commands go out and which code the sequence ends on.
    function automatic logic [3:0] model_init(input int bstep, input int bn);
        expected.delete();
        expected.push_back(spec_cmd(8'h40, 0));
        if (bstep == 0) return 4'd1;
        expected.push_back(spec_cmd(8'h48, 0));
        if (bstep == 1) return 4'd2;
        for (int a = 0; a < 1000; a++) begin
            expected.push_back(spec_cmd(8'h77, 0));
            if (bstep == 2 && a == 0) return 4'd3;
            expected.push_back(spec_cmd(8'h69, 0));
            if (bstep == 3 && a == 0) return 4'd4;
            if (a >= bn) break;
            if (a + 1 == MAX_RETRY) return 4'd5;
        end
        expected.push_back(spec_cmd(8'h50, 0));
        if (bstep == 4) return 4'd6;
        return 4'd0;
    endfunction

    function automatic logic [7:0] engine_resp(input logic [7:0] num);
        logic [7:0] f;
        case (num)
            8'h40: f = (bad_step == 0) ? bad_val : 8'h01;
            8'h48: f = (bad_step == 1) ? bad_val : 8'h01;
            8'h77: begin
                f = (bad_step == 2 && cmd55_seen == 0) ? bad_val : 8'($urandom_range(0, 1));
                cmd55_seen++;
            end
            8'h69: begin
                if (bad_step == 3 && acmd_seen == 0) f = bad_val;
                else f = (acmd_seen < busy_n) ? 8'h01 : 8'h00;
                acmd_seen++;
            end
            8'h50: f = (bad_step == 4) ? bad_val : 8'h00;
            8'h51: f = (bad_step == 5) ? bad_val : 8'h00;
            default: f = 8'h7F;
        endcase
        return f;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rd_valid) begin valid_cnt <= valid_cnt + 1; valid_data <= rd_data; end

    // Command engine: random response latency, cmd_done held after cmd_start drops.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                eng_phase = 0;
                cmd_done  = 1'b0;
            end else begin
                case (eng_phase)
                    0: if (cmd_start) begin
                        issued.push_back('{cmd_number, cmd_args, cmd_crc});
                        cur_num = cmd_number;
                        if (fall_cyc >= 0) check("gap_ok", 32'(cyc - fall_cyc >= GAP_CYCLES), 32'd1);
                        eng_delay = (stall_cmd8 && cmd_number == 8'h48) ? 1000000 : int'($urandom_range(0, 4));
                        eng_phase = 1;
                    end
                    1: if (eng_delay == 0) begin
                        resp_flags = engine_resp(cur_num);
                        resp_data  = (cur_num == 8'h51) ? rd_word : $urandom;
                        cmd_done   = 1'b1;
                        eng_phase  = 2;
                    end else eng_delay--;
                    2: if (!cmd_start) begin
                        fall_cyc  = cyc;
                        eng_hold  = $urandom_range(0, 12);
                        eng_phase = 3;
                    end
                    default: begin
                        if (cmd_start) done_viol = 1'b1;
                        if (eng_hold == 0) begin cmd_done = 1'b0; eng_phase = 0; end
                        else eng_hold--;
                    end
                endcase
            end
        end
    end

    task automatic wait_busy(input logic level, input int budget, input string tag);
        int n = 0;
        while (busy !== level && n < budget) begin
            @(negedge clk);
            n++;
            if (hold_rd && cmd_start && cmd_number == 8'h50) rd_req = 1'b0;
        end
        check(tag, 32'(busy), 32'(level));
    endtask

    task automatic compare_cmds(input string tag);
        check($sformatf("%s_ncmds", tag), 32'(issued.size()), 32'(expected.size()));
        for (int i = 0; i < issued.size() && i < expected.size(); i++) begin
            check($sformatf("%s_num%0d", tag, i),  32'(issued[i].num),  32'(expected[i].num));
            check($sformatf("%s_args%0d", tag, i), issued[i].args,      expected[i].args);
            check($sformatf("%s_crc%0d", tag, i),  32'(issued[i].crc),  32'(expected[i].crc));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cmd_start"}, 32'(cmd_start), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_init_done"}, 32'(init_done), 32'd0);
        check({tag, "_init_err"},  32'(init_err),  32'd0);
        check({tag, "_err_code"},  32'(err_code),  32'd0);
        check({tag, "_rd_ready"},  32'(rd_ready),  32'd0);
        check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
        check({tag, "_rd_data"},   rd_data,        32'd0);
        check({tag, "_cmd_fields"}, {cmd_number, cmd_crc, 16'd0} | cmd_args, 32'd0);
    endtask

    task automatic run_init(input int bstep, input int bn, input bit hold, output logic [3:0] code);
        int vbase;
        code       = model_init(bstep, bn);
        issued.delete();
        bad_step   = bstep;
        busy_n     = bn;
        acmd_seen  = 0;
        cmd55_seen = 0;
        fall_cyc   = -1;
        done_viol  = 1'b0;
        bad_val    = pick_bad(bstep);
        vbase      = valid_cnt;
        @(negedge clk);
        init_start = 1'b1;
        hold_rd    = hold;
        if (hold) begin rd_req = 1'b1; rd_addr = $urandom; end
        wait_busy(1'b1, 4, "init_start_busy");
        init_start = 1'b0;
        wait_busy(1'b0, 3000, "init_finish");
        repeat (GAP_CYCLES * 3) @(negedge clk);
        rd_req  = 1'b0;
        hold_rd = 1'b0;
        compare_cmds("init");
        check("init_done", 32'(init_done), 32'(code == 4'd0));
        check("init_err",  32'(init_err),  32'(code != 4'd0));
        check("err_code",  32'(err_code),  32'(code));
        check("rd_ready",  32'(rd_ready),  32'(code == 4'd0));
        check("init_no_valid", 32'(valid_cnt - vbase), 32'd0);
        check("done_wait", 32'(done_viol), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] word, input bit bad, output bit ok);
        int vbase;
        expected.delete();
        expected.push_back(spec_cmd(8'h51, addr));
        issued.delete();
        bad_step  = bad ? 5 : -1;
        bad_val   = pick_bad(5);
        rd_word   = word;
        fall_cyc  = -1;
        done_viol = 1'b0;
        vbase     = valid_cnt;
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = addr;
        @(negedge clk);
        rd_req  = 1'b0;
        rd_addr = $urandom;
        check("rd_ready_drop", 32'(rd_ready), 32'd0);
        wait_busy(1'b0, 2000, "rd_finish");
        repeat (GAP_CYCLES * 3) @(negedge clk);
        compare_cmds("read");
        check("rd_valid_cnt", 32'(valid_cnt - vbase), bad ? 32'd0 : 32'd1);
        if (!bad) begin
            check("rd_valid_data", valid_data, word);
            model_data = word;
        end
        check("rd_data",     rd_data,           model_data);
        check("rd_err_code", 32'(err_code),     bad ? 32'd7 : 32'd0);
        check("rd_init_err", 32'(init_err),     32'(bad));
        check("rd_ready_end", 32'(rd_ready),    32'(!bad));
        check("rd_init_done", 32'(init_done),   32'(!bad));
        check("rd_done_wait", 32'(done_viol),   32'd0);
        ok = !bad;
    endtask

    task automatic reset_mid_cmd8();
        int n = 0;
        issued.delete();
        bad_step   = -1;
        stall_cmd8 = 1'b1;
        fall_cyc   = -1;
        @(negedge clk);
        init_start = 1'b1;
        while (issued.size() < 2 && n < 500) begin @(negedge clk); n++; end
        check("stall_cmds", 32'(issued.size()), 32'd2);
        init_start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_zero("midrst");
        stall_cmd8 = 1'b0;
        model_data = 32'd0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] code;
        bit ok;
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: normal init with two busy ACMD41 answers, then the reference read.
        run_init(-1, 2, 1'b0, code);
        do_read(32'h0000_1234, 32'hDEAD_BEEF, 1'b0, ok);
        // Bad CMD0, then a restart out of ERROR.
        run_init(0, 0, 1'b0, code);
        run_init(-1, 0, 1'b0, code);
        // ACMD41 never ready: MAX_RETRY pairs then timeout.
        run_init(-1, 100, 1'b0, code);
        // Read request held through init (and asserted with the restart edge) is ignored.
        run_init(-1, 1, 1'b1, code);
        reset_mid_cmd8();
        run_init(-1, 1, 1'b0, code);

        for (int it = 0; it < 24; it++) begin
            int kind = $urandom_range(0, 9);
            int bs   = (kind >= 6) ? int'($urandom_range(0, 4)) : -1;
            int bn   = (kind == 5) ? 100 : int'($urandom_range(0, MAX_RETRY - 1));
            run_init(bs, bn, bit'($urandom_range(0, 1)), code);
            if (code == 4'd0) begin
                int nr = $urandom_range(1, 3);
                for (int r = 0; r < nr; r++) begin
                    do_read($urandom, $urandom, $urandom_range(0, 5) == 0, ok);
                    if (!ok) break;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
